matrix_loader: RTL and testbench

//   Upstream feeder for the complex matrix-product datapath. Accepts a valid/ready word stream and

---
 rtl/matrix_loader.sv | 135 +++++++++++++
 tb/tb_matrix_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Stream-to-RAM loader for the complex matrix-product datapath: fills R1, I1, R2, I2 row-major,
// fires one start pulse, then counts DIM*DIM result flags before returning to idle.
// Latency 1 cycle from accepted word to RAM strobe; in_ready is high for the whole LOAD state and stalls are unbounded.
module matrix_loader #(
  parameter int ANCHO_PALABRA = 32,
  parameter int DIM           = 3,
  localparam int AW           = $clog2(DIM*DIM-1)+1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     clr,
  input  logic [ANCHO_PALABRA-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ANCHO_PALABRA-1:0] wr_data,
  output logic [AW-1:0]            wr_addr,
  output logic                     we_R1,
  output logic                     we_I1,
  output logic                     we_R2,
  output logic                     we_I2,
  output logic                     signal,
  input  logic                     res_flag,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Last element index of one matrix; shared by the write address and the result counter.
  localparam logic [AW-1:0] LAST_IDX = AW'(DIM*DIM-1);

  state_t                   r_state;
  logic [AW-1:0]            r_addr;
  logic [1:0]               r_mat;
  logic [AW-1:0]            r_res_cnt;
  logic [ANCHO_PALABRA-1:0] r_wr_data;
  logic [AW-1:0]            r_wr_addr;
  logic [3:0]               r_we;      // bit order: R1, I1, R2, I2
  logic                     r_signal;
  logic                     r_done;

  logic                     w_in_ready;
  logic                     w_accept;

  assign w_in_ready = (r_state == S_LOAD);
  assign w_accept   = in_valid & w_in_ready;

  assign in_ready = w_in_ready;
  assign busy     = (r_state != S_IDLE);
  assign wr_data  = r_wr_data;
  assign wr_addr  = r_wr_addr;
  assign we_R1    = r_we[0];
  assign we_I1    = r_we[1];
  assign we_R2    = r_we[2];
  assign we_I2    = r_we[3];
  assign signal   = r_signal;
  assign done     = r_done;

  // Loader FSM: sequences the four matrix loads, the start pulse and the result count; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_mat     <= '0;
      r_res_cnt <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
      r_we      <= '0;
      r_signal  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Strobes and pulses are single-cycle unless re-armed below.
      r_we     <= '0;
      r_signal <= 1'b0;
      r_done   <= 1'b0;
      if (clr) begin
        // Abort: already-written RAM words stay; wr_data/wr_addr keep their last value.
        r_state   <= S_IDLE;
        r_addr    <= '0;
        r_mat     <= '0;
        r_res_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (load_start) begin
              r_state <= S_LOAD;
              r_addr  <= '0;
              r_mat   <= '0;
            end
          end
          S_LOAD: begin
            if (w_accept) begin
              r_wr_data <= in_data;
              r_wr_addr <= r_addr;
              r_we      <= 4'b0001 << r_mat;
              if (r_addr == LAST_IDX) begin
                r_addr <= '0;
                r_mat  <= r_mat + 2'd1;
                // Last word of I2: in_ready falls on this same edge.
                if (r_mat == 2'd3) begin
                  r_state <= S_START;
                end
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
          S_START: begin
            r_signal <= 1'b1;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            if (res_flag) begin
              if (r_res_cnt == LAST_IDX) begin
                r_done    <= 1'b1;
                r_res_cnt <= '0;
                r_state   <= S_IDLE;
              end else begin
                r_res_cnt <= r_res_cnt + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: scoreboarded RAM writes, start pulse timing,
// result counting, async reset mid-load, clr abort and ignored-input cases.
module tb_matrix_loader;

  localparam int W   = 32;
  localparam int DIM = 3;
  localparam int AW  = 4;

  typedef struct packed {
    logic [1:0]    mat;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          clr;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] wr_addr;
  logic          we_R1, we_I1, we_R2, we_I2;
  logic          signal;
  logic          res_flag;
  logic          busy;
  logic          done;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   sig_cnt  = 0;
  int   done_cnt = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [3:0] mon_we;
  logic [1:0] mon_mat;

  int gaps[9] = '{0, 2, 1, 3, 0, 0, 5, 1, 2};

  matrix_loader #(.ANCHO_PALABRA(W), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_data(wr_data), .wr_addr(wr_addr),
    .we_R1(we_R1), .we_I1(we_I1), .we_R2(we_R2), .we_I2(we_I2),
    .signal(signal), .res_flag(res_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word (valid left high for the caller to drop) and record the expected write.
  task automatic send_word(input logic [W-1:0] d, input logic [1:0] m, input logic [AW-1:0] a);
    exp_t e;
    in_data  = d;
    in_valid = 1'b1;
    chk("in_ready_load", in_ready, 1);
    e.mat  = m;
    e.addr = a;
    e.data = d;
    q.push_back(e);
    tick();
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (signal) sig_cnt++;
      if (done) done_cnt++;
      chk("signal_done_overlap", signal & done, 0);
      mon_we = {we_I2, we_R2, we_I1, we_R1};
      if (mon_we != 4'b0000) begin
        chk("we_onehot", $onehot(mon_we), 1);
        chk("write_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          mon_e   = q.pop_front();
          mon_mat = we_R1 ? 2'd0 : we_I1 ? 2'd1 : we_R2 ? 2'd2 : 2'd3;
          chk("wr_mat", mon_mat, mon_e.mat);
          chk("wr_addr", wr_addr, mon_e.addr);
          chk("wr_data", wr_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; clr = 1'b0;
    in_data = '0; in_valid = 1'b0; res_flag = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", {we_R1, we_I1, we_R2, we_I2}, 0);
    chk("rst_signal_done", {signal, done}, 0);
    chk("rst_wr", {wr_data, wr_addr}, 0);
    #10 rst = 1'b0;
    tick();

    // Reset in the middle of a load.
    pulse_load_start();
    for (int i = 0; i < 5; i++) send_word(32'hDEAD_0000 + i, 2'd0, AW'(i));
    in_valid = 1'b0;
    #5;
    chk("pre_rst_queue_empty", q.size(), 0);
    chk("pre_rst_wr_data", wr_data, 32'hDEAD_0004);
    rst = 1'b1;
    #1;
    chk("midload_rst_outputs", {in_ready, busy, we_R1, we_I1, we_R2, we_I2, signal, done}, 0);
    chk("midload_rst_wr", {wr_data, wr_addr}, 0);
    #2 rst = 1'b0;
    tick();
    pulse_load_start();
    send_word(32'h77, 2'd0, 4'd0);
    send_word(32'h78, 2'd0, 4'd1);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_after_rst_busy", busy, 0);

    // Full load with valid held high.
    pulse_load_start();
    chk("load_busy", busy, 1);
    for (int i = 0; i < 36; i++) send_word(W'(i), 2'(i / 9), AW'(i % 9));
    in_valid = 1'b0;
    chk("start_in_ready", in_ready, 0);
    chk("start_busy", busy, 1);
    chk("start_no_signal_yet", signal, 0);
    tick();
    chk("signal_pulse", signal, 1);
    chk("wr_hold_data", wr_data, 35);
    chk("wr_hold_addr", wr_addr, 8);

    // Result counting, irregular spacing, with load_start ignored in RUN.
    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("run_busy", busy, 1);
      end
      res_flag = 1'b1;
      tick();
      res_flag = 1'b0;
      if (i < 8) chk("done_early", done, 0);
      else begin
        chk("done_pulse", done, 1);
        chk("busy_after_done", busy, 0);
      end
    end
    tick();
    chk("done_one_cycle", done, 0);
    res_flag = 1'b1;
    tick();
    res_flag = 1'b0;
    chk("idle_res_flag_busy", busy, 0);
    chk("idle_res_flag_done", done, 0);
    tick();
    chk("done_count", done_cnt, 1);
    chk("signal_count", sig_cnt, 1);

    // Stalled load, load_start ignored in LOAD.
    pulse_load_start();
    for (int i = 0; i < 36; i++) begin
      send_word(W'(i), 2'(i / 9), AW'(i % 9));
      in_valid = 1'b0;
      if (i < 35) begin
        load_start = (i == 10);
        chk("in_ready_stall", in_ready, 1);
        tick();
        load_start = 1'b0;
      end
    end
    chk("stall_start_in_ready", in_ready, 0);
    tick();
    chk("stall_signal_pulse", signal, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("stall_clr_busy", busy, 0);
    chk("stall_signal_count", sig_cnt, 2);

    // clr at word 20 with a word offered: clr wins, no write.
    pulse_load_start();
    for (int i = 0; i < 20; i++) send_word(W'(100 + i), 2'(i / 9), AW'(i % 9));
    in_data = 32'd999;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_in_ready", in_ready, 0);
    chk("clr_busy", busy, 0);
    chk("clr_no_strobe", {we_R1, we_I1, we_R2, we_I2}, 0);

    // clr together with load_start in IDLE stays idle.
    clr = 1'b1;
    load_start = 1'b1;
    tick();
    clr = 1'b0;
    load_start = 1'b0;
    chk("clr_vs_load_start_busy", busy, 0);
    chk("clr_vs_load_start_ready", in_ready, 0);

    // Fresh load restarts at R1 address 0.
    pulse_load_start();
    send_word(32'h5A5A, 2'd0, 4'd0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("final_queue_empty", q.size(), 0);
    chk("final_wr_data", wr_data, 32'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
